// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiplier front end: float element width,
// default matrix dimension and the loader state encoding.
package mat_pkg;

  localparam int FP_W = 27;
  localparam int N_DEFAULT = 4;

  typedef logic [FP_W-1:0] fp_t;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

endpackage

// File: rtl/mat_buffer.sv
// One N*N bank of element registers, written one slot at a time and exposed as
// a flat row-major bus (slot k at bits FP_W*k +: FP_W).
module mat_buffer #(
  parameter int N     = 4,
  parameter int FP_W  = 27,
  parameter int IDX_W = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [FP_W-1:0]       wr_data,
  output logic [FP_W*N*N-1:0]   mat
);

  logic [FP_W-1:0] slot [N*N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N * N; k++) slot[k] <= '0;
    end else if (wr_en) begin
      slot[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < N * N; g++) begin : g_flat
    assign mat[FP_W*g +: FP_W] = slot[g];
  end

endmodule

// File: rtl/mat_loader.sv
// Stages a row-major element stream into operand matrices A and B, then holds
// them stable for the combinational multiplier until the consumer acknowledges.
module mat_loader
  import mat_pkg::*;
#(
  parameter int N    = mat_pkg::N_DEFAULT,
  parameter int FP_W = mat_pkg::FP_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FP_W-1:0]                 in_data,
  input  logic                            abort,
  output logic [FP_W*N*N-1:0]             mat_a,
  output logic [FP_W*N*N-1:0]             mat_b,
  output logic                            mat_valid,
  input  logic                            mat_ack,
  output logic [$clog2(2*N*N+1)-1:0]      fill_count
);

  localparam int IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int CNT_W = $clog2(2 * N * N + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   fill_nx;
  logic               xfer;
  logic               we_a, we_b;

  // Ready depends on state only so the producer never sees a combinational loop.
  assign in_ready  = ((state == LOAD_A) || (state == LOAD_B)) && !reset;
  assign mat_valid = (state == FULL);
  assign xfer      = in_valid && in_ready && !abort;
  assign we_a      = xfer && (state == LOAD_A);
  assign we_b      = xfer && (state == LOAD_B);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    fill_nx  = fill_count;
    if (abort) begin
      state_nx = LOAD_A;
      idx_nx   = '0;
      fill_nx  = '0;
    end else begin
      unique case (state)
        LOAD_A, LOAD_B: begin
          if (xfer) begin
            fill_nx = fill_count + CNT_W'(1);
            if (idx == LAST_IDX) begin
              idx_nx   = '0;
              state_nx = (state == LOAD_A) ? LOAD_B : FULL;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end
        end
        FULL: begin
          if (mat_ack) begin
            state_nx = LOAD_A;
            fill_nx  = '0;
          end
        end
        default: begin
          state_nx = LOAD_A;
          idx_nx   = '0;
          fill_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD_A;
      idx        <= '0;
      fill_count <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      fill_count <= fill_nx;
    end
  end

  // Matrix banks are deliberately not cleared on ack; stale data is overwritten by the next load.
  mat_buffer #(.N(N), .FP_W(FP_W), .IDX_W(IDX_W)) u_buf_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (we_a),
    .wr_idx  (idx),
    .wr_data (in_data),
    .mat     (mat_a)
  );

  mat_buffer #(.N(N), .FP_W(FP_W), .IDX_W(IDX_W)) u_buf_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (we_b),
    .wr_idx  (idx),
    .wr_data (in_data),
    .mat     (mat_b)
  );

endmodule

// File: tb/tb_mat_loader.sv
// Randomized bench for mat_loader: a stream-level model tracks accepted elements
// and the expected matrices, and every cycle's outputs are compared against it.
module tb_mat_loader;
  import mat_pkg::*;

  localparam int N   = 4;
  localparam int NN  = N * N;
  localparam int NN2 = 2 * NN;
  localparam int W   = FP_W * NN;
  localparam int CW  = $clog2(NN2 + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FP_W-1:0] in_data = '0;
  logic            abort = 1'b0;
  logic [W-1:0]    mat_a, mat_b;
  logic            mat_valid;
  logic            mat_ack = 1'b0;
  logic [CW-1:0]   fill_count;

  int checks = 0;
  int errors = 0;

  // Reference model: number of accepted elements in the current load and the
  // contents each matrix should hold.
  int  cnt = 0;
  fp_t ref_a [NN];
  fp_t ref_b [NN];

  always #5 clk = ~clk;

  mat_loader #(.N(N), .FP_W(FP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .abort      (abort),
    .mat_a      (mat_a),
    .mat_b      (mat_b),
    .mat_valid  (mat_valid),
    .mat_ack    (mat_ack),
    .fill_count (fill_count)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input fp_t m [NN]);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NN; k++) v[k*FP_W +: FP_W] = m[k];
    return v;
  endfunction

  task automatic model_clear();
    cnt = 0;
    for (int k = 0; k < NN; k++) begin
      ref_a[k] = '0;
      ref_b[k] = '0;
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", W'(in_ready), W'(!reset && cnt < NN2));
    chk("mat_valid", W'(mat_valid), W'(!reset && cnt == NN2));
    chk("fill_count", W'(fill_count), W'(cnt));
    chk("mat_a", mat_a, pack(ref_a));
    chk("mat_b", mat_b, pack(ref_b));
  endtask

  // Called at posedge+1: drive, check at mid-cycle, advance the model, wait an edge.
  task automatic cycle(input logic v, input logic [FP_W-1:0] d, input logic ab, input logic ak);
    in_valid = v;
    in_data  = d;
    abort    = ab;
    mat_ack  = ak;
    #4;
    check_outputs();
    if (ab) begin
      cnt = 0;
    end else if (cnt == NN2) begin
      if (ak) cnt = 0;
    end else if (v) begin
      if (cnt < NN) ref_a[cnt] = d;
      else          ref_b[cnt - NN] = d;
      cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base, input bit rnd, input bit gaps);
    int k;
    int guard;
    logic v;
    logic [FP_W-1:0] d;
    k = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = rnd ? FP_W'($urandom) : FP_W'(base + k);
      cycle(v, d, 1'b0, gaps ? 1'($urandom_range(0, 1)) : 1'b0);
      if (v) k++;
      guard++;
    end
    chk("load_bound", W'(guard < 400), W'(1));
  endtask

  task automatic async_reset();
    in_valid = 1'b1;
    in_data  = FP_W'($urandom);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    async_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Full-rate sequential load 1..32, then spot-check corners.
    load(NN2, 1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("a_first", W'(mat_a[26:0]), W'(1));
    chk("a_last", W'(mat_a[431:405]), W'(16));
    chk("b_first", W'(mat_b[26:0]), W'(17));
    chk("b_last", W'(mat_b[431:405]), W'(32));

    // Held in FULL with elements offered, then ack.
    for (int i = 0; i < 10; i++) cycle(1'b1, FP_W'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, FP_W'(101), 1'b0, 1'b0);
    cnt = cnt;

    // Second load 101..132 with gaps (first element above already accepted).
    load(NN2 - 1, 102, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("a2_first", W'(mat_a[26:0]), W'(101));
    chk("b2_last", W'(mat_b[431:405]), W'(132));
    cycle(1'b1, FP_W'($urandom), 1'b0, 1'b1);

    // Abort at fill_count 20 with a concurrent offer.
    load(20, 0, 1'b1, 1'b0);
    chk("fill_20", W'(fill_count), W'(20));
    cycle(1'b1, FP_W'(27'h7ffffff), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    load(NN2, 0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset mid B load, then a complete random load.
    load(24, 0, 1'b1, 1'b0);
    chk("fill_24", W'(fill_count), W'(24));
    async_reset();
    load(NN2, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, FP_W'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_loader.md
# mat_loader

Input staging buffer that sits directly upstream of the combinational matrix multiplier. It accepts a stream of 27-bit floating-point elements over a valid/ready handshake and assembles two N×N operand matrices, A then B, into flat registered buses. Once both matrices are complete, it presents them as stable inputs to the multiplier. The buffer holds those inputs until the consumer acknowledges them, then refills.

## Interface
Parameters:
- `N`, default 4: matrix dimension. Each matrix holds N*N elements.
- `FP_W`, default 27: element width, fixed to the codebase float format.

Ports:
- `clk`  in  1  sole clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a valid element.
- `in_ready`  out  1  loader can accept an element this cycle.
- `in_data`  in  FP_W  element, row-major order, all A elements before all B elements.
- `abort`  in  1  synchronous; discards the partial load and returns to empty.
- `mat_a`  out  FP_W*N*N  matrix A; element (i,j) occupies bits FP_W*(i*N+j) +: FP_W.
- `mat_b`  out  FP_W*N*N  matrix B, same layout as `mat_a`.
- `mat_valid`  out  1  `mat_a` and `mat_b` are complete and stable.
- `mat_ack`  in  1  consumer has taken the matrices; meaningful only while `mat_valid`=1.
- `fill_count`  out  $clog2(2*N*N+1)  number of elements accepted in the current load.

## Operation
- States:
  - `LOAD_A`: filling A. Reset state.
  - `LOAD_B`: filling B.
  - `FULL`: both matrices presented to the consumer.
- `in_ready` = (state is `LOAD_A` or `LOAD_B`) and not `reset`. It is combinational from state only and never depends on `in_valid`.
- Transfer occurs when `in_valid` & `in_ready` are both high. The element is written to slot `idx`, the in-matrix index 0..N*N-1, of the active matrix. `idx` then increments and `fill_count` increments.
- In `LOAD_A`, a transfer with `idx`=N*N-1 sets `idx` to 0 and moves to `LOAD_B`.
- In `LOAD_B`, a transfer with `idx`=N*N-1 sets `idx` to 0 and moves to `FULL`.
- `mat_valid` = (state is `FULL`).
- While in `FULL`:
  - `in_valid` is ignored.
  - `mat_a` and `mat_b` must not change.
- `mat_ack` high while in `FULL` moves to `LOAD_A` and clears `fill_count` to 0.
- `mat_ack` in any other state is ignored.
- Matrix registers are not cleared on ack. Stale data remains until overwritten.
- `abort` (any state):
  - Next state is `LOAD_A`; `idx` and `fill_count` clear to 0.
  - Any transfer in the same cycle is discarded.
  - `abort` takes priority over `mat_ack` and over transfers.
- Reset:
  - State `LOAD_A`; `idx`, `fill_count` = 0.
  - `mat_a`, `mat_b` = all zeros.
  - `mat_valid` = 0; `in_ready` = 0 while `reset` is high.
- Reset asserted mid-load or in `FULL` takes effect immediately and asynchronously. Partial data is lost.
- No arithmetic is performed on elements. Data passes through bit-exact.

## Timing
- One element accepted per cycle at full rate. There are no bubbles between A and B.
- `in_ready` goes low the cycle after the last B element is accepted, together with `mat_valid` going high. Latency from the last accept to `mat_valid` is 1 cycle.
- Ack handling:
  - `mat_ack` is sampled on the edge.
  - `mat_valid` falls and `in_ready` rises in the cycle after the ack cycle.
  - There is no same-cycle refill.
- Minimum period between `mat_valid` rising edges is 2*N*N+1 cycles, with `mat_ack` held high.
- The consumer (the multiplier) is combinational. Results are valid while `mat_valid` is high, after the multiplier's propagation delay.

## Structure
- Shared package `mat_pkg`:
  - `FP_W` = 27 and the default `N`.
  - `fp_t` (logic [FP_W-1:0]).
  - The state enum {`LOAD_A`, `LOAD_B`, `FULL`}.
- Sub-module `mat_buffer`: one N*N element register bank with write-enable and index. It is instantiated twice, for A and B.
- The top level holds the FSM, the index counter, `fill_count`, and the handshake.

## Test plan
- Reset: assert `reset` mid-cycle → `mat_valid`=0, `in_ready`=0, `fill_count`=0, `mat_a`=`mat_b`=0 immediately. After release, `in_ready`=1.
- Full-rate load, N=4: send 1..32 back-to-back → `mat_valid`=1 exactly 1 cycle after the 32nd accept. `mat_a`[26:0]=1, `mat_a`[431:405]=16, `mat_b`[26:0]=17, `mat_b`[431:405]=32.
- Backpressure and gaps: random `in_valid` gaps during the load → same final matrices. `fill_count` tracks accepts exactly. Elements offered in `FULL` are not accepted and do not alter the outputs.
- Delayed ack:
  - Hold `mat_ack` low for 10 cycles in `FULL` → outputs stable and `in_ready`=0 throughout.
  - Then ack → `mat_valid`=0 and `in_ready`=1 on the next cycle.
  - A second load of 101..132 produces the new values.
- Abort at `fill_count`=20, with `in_valid` high in the same cycle → that element is discarded and `fill_count`=0. A fresh 32-element load completes normally.
- Reset mid-`LOAD_B` (`fill_count`=24) → immediate return to the reset values. A subsequent full load is correct.
